// File: rtl/assoc_buffer_lru.sv
// Fully associative key->data buffer with round-robin replacement.
// Option: ASSOC_BUFFER_SATURATE_EN makes INCR saturate instead of wrap.
module assoc_buffer_lru #(
    parameter int KEY_WIDTH  = 2,
    parameter int DATA_WIDTH = 4,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [2:0]                   ctrl,
    input  logic [KEY_WIDTH-1:0]         key,
    input  logic [DATA_WIDTH-1:0]        data_input,
    output logic [DATA_WIDTH-1:0]        data_output,
    output logic                         valid,
    output logic                         evicted,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_INCR  = 3'b010;
    localparam logic [2:0] OP_READ  = 3'b011;
    localparam logic [2:0] OP_DEL   = 3'b100;
    localparam logic [2:0] OP_CLEAR = 3'b101;

    logic                  r_used [DEPTH];
    logic [KEY_WIDTH-1:0]  r_key  [DEPTH];
    logic [DATA_WIDTH-1:0] r_data [DEPTH];
    logic [PW-1:0]         r_victim;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_valid;
    logic                  r_evicted;
    logic [CW-1:0]         r_count;

    logic                  w_hit;
    logic [PW-1:0]         w_hit_idx;
    logic                  w_free;
    logic [PW-1:0]         w_free_idx;
    logic [DATA_WIDTH-1:0] w_hit_data;
    logic [DATA_WIDTH-1:0] w_inc;
    logic [PW-1:0]         w_victim_nxt;

    // Parallel key compare; unique keys mean at most one slot matches
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_used[i] && (r_key[i] == key)) begin
                w_hit     = 1'b1;
                w_hit_idx = PW'(i);
            end
        end
    end

    // Lowest-index free slot (scan downwards so the lowest wins)
    always_comb begin
        w_free     = 1'b0;
        w_free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!r_used[i]) begin
                w_free     = 1'b1;
                w_free_idx = PW'(i);
            end
        end
    end

    // Incremented value of the hit slot, wrapping or saturating
    always_comb begin
        w_hit_data = r_data[w_hit_idx];
`ifdef ASSOC_BUFFER_SATURATE_EN
        if (&w_hit_data) begin
            w_inc = w_hit_data;
        end else begin
            w_inc = w_hit_data + 1'b1;
        end
`else
        w_inc = w_hit_data + 1'b1;
`endif
    end

    // Round-robin victim pointer successor
    always_comb begin
        if (r_victim == PW'(DEPTH - 1)) begin
            w_victim_nxt = '0;
        end else begin
            w_victim_nxt = r_victim + 1'b1;
        end
    end

    // Slot storage, replacement pointer and registered results
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_used[i] <= 1'b0;
                r_key[i]  <= '0;
                r_data[i] <= '0;
            end
            r_victim  <= '0;
            r_dout    <= '0;
            r_valid   <= 1'b0;
            r_evicted <= 1'b0;
            r_count   <= '0;
        end else begin
            r_dout    <= '0;
            r_valid   <= 1'b0;
            r_evicted <= 1'b0;
            case (ctrl)
                OP_LOAD: begin
                    r_dout  <= data_input;
                    r_valid <= 1'b1;
                    if (w_hit) begin
                        r_data[w_hit_idx] <= data_input;
                    end else if (w_free) begin
                        r_used[w_free_idx] <= 1'b1;
                        r_key[w_free_idx]  <= key;
                        r_data[w_free_idx] <= data_input;
                        r_count            <= r_count + 1'b1;
                    end else begin
                        r_key[r_victim]  <= key;
                        r_data[r_victim] <= data_input;
                        r_evicted        <= 1'b1;
                        r_victim         <= w_victim_nxt;
                    end
                end
                OP_INCR: begin
                    if (w_hit) begin
                        r_data[w_hit_idx] <= w_inc;
                        r_dout            <= w_inc;
                        r_valid           <= 1'b1;
                    end
                end
                OP_READ: begin
                    if (w_hit) begin
                        r_dout  <= w_hit_data;
                        r_valid <= 1'b1;
                    end
                end
                OP_DEL: begin
                    if (w_hit) begin
                        r_used[w_hit_idx] <= 1'b0;
                        r_dout            <= w_hit_data;
                        r_valid           <= 1'b1;
                        r_count           <= r_count - 1'b1;
                    end
                end
                OP_CLEAR: begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_used[i] <= 1'b0;
                    end
                    r_victim <= '0;
                    r_count  <= '0;
                end
                OP_NOP: begin
                end
                default: begin
                end
            endcase
        end
    end

    assign data_output = r_dout;
    assign valid       = r_valid;
    assign evicted     = r_evicted;
    assign count       = r_count;
    assign full        = (r_count == CW'(DEPTH));

endmodule

// File: tb/tb_assoc_buffer_lru.sv
// Scoreboard bench for assoc_buffer_lru (KEY 2, DATA 4, DEPTH 2).
// Directed scenarios followed by random ops against a slot-level model.
module tb_assoc_buffer_lru;

    localparam int KW = 2;
    localparam int DW = 4;
    localparam int DP = 2;
    localparam int CW = $clog2(DP + 1);

    typedef struct packed {
        logic [DW-1:0] d;
        logic          v;
        logic          e;
        logic [CW-1:0] c;
        logic          f;
    } resp_t;

    logic          clk;
    logic          rst;
    logic [2:0]    ctrl;
    logic [KW-1:0] key;
    logic [DW-1:0] data_input;
    logic [DW-1:0] data_output;
    logic          valid;
    logic          evicted;
    logic [CW-1:0] count;
    logic          full;

    assoc_buffer_lru #(
        .KEY_WIDTH (KW),
        .DATA_WIDTH(DW),
        .DEPTH     (DP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ctrl       (ctrl),
        .key        (key),
        .data_input (data_input),
        .data_output(data_output),
        .valid      (valid),
        .evicted    (evicted),
        .count      (count),
        .full       (full)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    resp_t q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    // Reference model: each slot holds a key (or is empty) and a value
    bit m_used[DP];
    int m_key[DP];
    int m_data[DP];
    int m_vic;

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < DP; i++) if (m_used[i]) n++;
        return n;
    endfunction

    task automatic issue(input bit r, input int c, input int k, input int d);
        resp_t e;
        int    h;
        int    fr;
        int    nv;
        @(negedge clk);
        rst        = r;
        ctrl       = 3'(c);
        key        = KW'(k);
        data_input = DW'(d);
        e = '0;
        if (r) begin
            for (int i = 0; i < DP; i++) m_used[i] = 0;
            m_vic = 0;
        end else begin
            h  = -1;
            fr = -1;
            for (int i = 0; i < DP; i++)
                if (m_used[i] && m_key[i] == k) h = i;
            for (int i = DP - 1; i >= 0; i--)
                if (!m_used[i]) fr = i;
            case (c)
                1: begin
                    e.d = DW'(d);
                    e.v = 1;
                    if (h >= 0) m_data[h] = d;
                    else if (fr >= 0) begin
                        m_used[fr] = 1;
                        m_key[fr]  = k;
                        m_data[fr] = d;
                    end else begin
                        m_key[m_vic]  = k;
                        m_data[m_vic] = d;
                        m_vic = (m_vic + 1) % DP;
                        e.e = 1;
                    end
                end
                2: if (h >= 0) begin
                    nv = m_data[h] + 1;
                    if (nv > 15) begin
`ifdef ASSOC_BUFFER_SATURATE_EN
                        nv = 15;
`else
                        nv = 0;
`endif
                    end
                    m_data[h] = nv;
                    e.d = DW'(nv);
                    e.v = 1;
                end
                3: if (h >= 0) begin
                    e.d = DW'(m_data[h]);
                    e.v = 1;
                end
                4: if (h >= 0) begin
                    e.d = DW'(m_data[h]);
                    e.v = 1;
                    m_used[h] = 0;
                end
                5: begin
                    for (int i = 0; i < DP; i++) m_used[i] = 0;
                    m_vic = 0;
                end
                default: ;
            endcase
            e.c = CW'(m_count());
            e.f = (m_count() == DP);
        end
        q.push_back(e);
    endtask

    // Monitor: every clock the DUT presents a registered response
    always @(posedge clk) begin
        resp_t g;
        resp_t x;
        #1;
        if (q.size() > 0) begin
            x = q.pop_front();
            g = '{data_output, valid, evicted, count, full};
            n_checks++;
            if (g !== x) begin
                n_fail++;
                $display("FAIL resp @%0t: got d=%h v=%b e=%b c=%0d f=%b, expected d=%h v=%b e=%b c=%0d f=%b",
                         $time, g.d, g.v, g.e, g.c, g.f, x.d, x.v, x.e, x.c, x.f);
            end
        end
    end

    initial begin
        rst        = 1'b1;
        ctrl       = '0;
        key        = '0;
        data_input = '0;
        // Scenario 1: load, increment, wrap
        issue(1, 0, 0, 0);
        issue(0, 1, 1, 14);
        issue(0, 2, 1, 0);
        issue(0, 2, 1, 0);
        // Scenario 2: misses after reset
        issue(1, 0, 0, 0);
        issue(0, 3, 2, 0);
        issue(0, 2, 3, 0);
        // Scenario 3: fill and evict
        issue(1, 0, 0, 0);
        issue(0, 1, 0, 3);
        issue(0, 1, 1, 5);
        issue(0, 1, 2, 7);
        issue(0, 3, 0, 0);
        issue(0, 3, 2, 0);
        // Scenario 4: overwrite in place
        issue(1, 0, 0, 0);
        issue(0, 1, 1, 5);
        issue(0, 1, 1, 9);
        issue(0, 3, 1, 0);
        // Scenario 5: delete then refill without eviction
        issue(1, 0, 0, 0);
        issue(0, 1, 0, 3);
        issue(0, 1, 1, 5);
        issue(0, 4, 1, 0);
        issue(0, 1, 3, 10);
        // Scenario 6: reset wins over LOAD
        issue(0, 1, 2, 4);
        issue(1, 1, 1, 14);
        issue(0, 3, 1, 0);
        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            issue($urandom_range(0, 99) < 2, $urandom_range(0, 7),
                  $urandom_range(0, 3), $urandom_range(0, 15));
        end
        issue(0, 0, 0, 0);
        @(posedge clk);
        #3;
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d responses left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
